pattern_gen_ec: RTL and testbench

PATTERN_GEN_EC -- requirements
Module: pattern_gen_ec

---
 rtl/pattern_ec_pkg.sv | 42 ++++
 rtl/pattern_ec_fifo.sv | 73 +++++++
 rtl/pattern_gen_ec.sv | 184 ++++++++++++++++++
 tb/tb_pattern_gen_ec.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_ec_pkg.sv
// Shared definitions for the E/C pattern generator.
//   - FSM state encoding (GAP present only with PATTERN_GEN_EC_GAP_EN defined)
//   - two-bit symbol payload {msb, lsb} and the symbol constants
//   - letter codes and a helper that maps a letter to its tail symbol
package pattern_ec_pkg;

    localparam int unsigned HOLD_W = 4;

    localparam logic LETTER_E = 1'b0;
    localparam logic LETTER_C = 1'b1;

    typedef struct packed {
        logic msb;
        logic lsb;
    } symbol_t;

    localparam symbol_t SYM_HEAD   = symbol_t'(2'b11);
    localparam symbol_t SYM_E_TAIL = symbol_t'(2'b10);
    localparam symbol_t SYM_C_TAIL = symbol_t'(2'b00);
    localparam symbol_t SYM_IDLE   = symbol_t'(2'b00);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
`ifdef PATTERN_GEN_EC_GAP_EN
        ST_GAP  = 2'd3,
`endif
        ST_TAIL = 2'd2
    } state_t;

    // Second symbol of a letter.
    function automatic symbol_t tail_symbol(input logic code);
        if (code == LETTER_E) begin
            return SYM_E_TAIL;
        end else if (code == LETTER_C) begin
            return SYM_C_TAIL;
        end else begin
            return SYM_IDLE;
        end
    endfunction

endpackage

// File: rtl/pattern_ec_fifo.sv
// Two-entry, one-bit-wide request FIFO for the pattern generator.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write request (ignored when full)
//   pop             read request (ignored when empty)
//   pop_data_c      head entry, combinational from storage
//   full, empty     registered status flags
//   count           registered occupancy (0..2)
module pattern_ec_fifo (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       push_data,
    input  logic       pop,
    output logic       pop_data_c,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    logic             mem [DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push_ok;
    logic             pop_ok;
    logic [CNT_W-1:0] count_n;

    assign push_ok    = push & ~full;
    assign pop_ok     = pop & ~empty;
    assign pop_data_c = mem[rd_ptr];

    // Occupancy update; push and pop together leave the count unchanged.
    always_comb begin
        count_n = count;
        case ({push_ok, pop_ok})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
        endcase
    end

    // Storage is not reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_n;
            full  <= (count_n == CNT_W'(DEPTH));
            empty <= (count_n == '0);
        end
    end

endmodule

// File: rtl/pattern_gen_ec.sv
// E/C two-level symbol pattern generator.
// Each letter is sent as a HEAD symbol (11) followed by a TAIL symbol
// (10 for E, 00 for C), each held for HOLD_CYCLES clocks. Requests are
// queued in a two-entry FIFO; queued letters follow back to back.
// Optional macro PATTERN_GEN_EC_GAP_EN: insert a 00 gap of HOLD_CYCLES
// clocks (tx_active held high) after every TAIL.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   letter_valid  request offered
//   letter_code   0 = E, 1 = C
//   letter_ready  request accepted when letter_valid=1 (FIFO not full)
//   OutputMSB     symbol bit 1, registered
//   OutputLSB     symbol bit 0, registered
//   tx_active     high while a symbol or gap is driven
//   letter_done   pulse on the last hold cycle of a letter's TAIL
module pattern_gen_ec
    import pattern_ec_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic letter_valid,
    input  logic letter_code,
    output logic letter_ready,
    output logic OutputMSB,
    output logic OutputLSB,
    output logic tx_active,
    output logic letter_done
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_t            state;
    state_t            state_n;
    logic [HOLD_W-1:0] cnt;
    logic [HOLD_W-1:0] cnt_n;
    logic              code;
    logic              code_n;
    logic              pop;
    logic              in_reset;

    symbol_t           sym_q;
    symbol_t           sym_n;
    logic              done_n;
    logic              active_n;

    logic              fifo_push;
    logic              fifo_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic              unused_count;

    // Ready depends only on registered state, never on letter_valid.
    assign letter_ready = ~fifo_full & ~in_reset;
    assign fifo_push    = letter_valid & letter_ready;
    assign unused_count = ^fifo_count;

    pattern_ec_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_data  (letter_code),
        .pop        (pop),
        .pop_data_c (fifo_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Next-state logic: hold counter runs down to zero in each state.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        code_n  = code;
        pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    code_n  = fifo_data;
                    state_n = ST_HEAD;
                    cnt_n   = HOLD_LOAD;
                end
            end
            ST_HEAD: begin
                if (cnt == '0) begin
                    state_n = ST_TAIL;
                    cnt_n   = HOLD_LOAD;
                end else begin
                    cnt_n = cnt - HOLD_W'(1);
                end
            end
            ST_TAIL: begin
                if (cnt == '0) begin
`ifdef PATTERN_GEN_EC_GAP_EN
                    state_n = ST_GAP;
                    cnt_n   = HOLD_LOAD;
`else
                    // Chain straight into the next queued letter.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        code_n  = fifo_data;
                        state_n = ST_HEAD;
                        cnt_n   = HOLD_LOAD;
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end
`endif
                end else begin
                    cnt_n = cnt - HOLD_W'(1);
                end
            end
`ifdef PATTERN_GEN_EC_GAP_EN
            ST_GAP: begin
                if (cnt == '0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        code_n  = fifo_data;
                        state_n = ST_HEAD;
                        cnt_n   = HOLD_LOAD;
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end
                end else begin
                    cnt_n = cnt - HOLD_W'(1);
                end
            end
`endif
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Output decode of the current state; registered below, so the pins
    // follow the state by one clock.
    always_comb begin
        sym_n    = SYM_IDLE;
        done_n   = 1'b0;
        active_n = 1'b1;
        case (state)
            ST_IDLE: active_n = 1'b0;
            ST_HEAD: sym_n = SYM_HEAD;
            ST_TAIL: begin
                sym_n  = tail_symbol(code);
                done_n = (cnt == '0);
            end
`ifdef PATTERN_GEN_EC_GAP_EN
            ST_GAP:  sym_n = SYM_IDLE;
`endif
            default: active_n = 1'b0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            code        <= LETTER_E;
            sym_q       <= SYM_IDLE;
            letter_done <= 1'b0;
            tx_active   <= 1'b0;
            in_reset    <= 1'b1;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            code        <= code_n;
            sym_q       <= sym_n;
            letter_done <= done_n;
            tx_active   <= active_n;
            in_reset    <= 1'b0;
        end
    end

    assign OutputMSB = sym_q.msb;
    assign OutputLSB = sym_q.lsb;

endmodule

// File: tb/tb_pattern_gen_ec.sv
// Scoreboard bench for pattern_gen_ec: one instance with HOLD_CYCLES=2 and
// one with HOLD_CYCLES=1. Expected symbol streams are queued when a letter
// is accepted; per-instance monitors compare on every active output cycle.
module tb_pattern_gen_ec;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic v2 = 1'b0, c2 = 1'b0, r2, m2, l2, a2, d2;
    logic v1 = 1'b0, c1 = 1'b0, r1, m1, l1, a1, d1;

    int compared   = 0;
    int mismatched = 0;
    int bursts2    = 0;
    int bursts1    = 0;
    logic a2_prev  = 1'b0;
    logic a1_prev  = 1'b0;

    // Entries are {msb, lsb, letter_done}.
    logic [2:0] q2[$];
    logic [2:0] q1[$];

    pattern_gen_ec #(.HOLD_CYCLES(2)) u_dut2 (
        .clk          (clk),
        .rst          (rst),
        .letter_valid (v2),
        .letter_code  (c2),
        .letter_ready (r2),
        .OutputMSB    (m2),
        .OutputLSB    (l2),
        .tx_active    (a2),
        .letter_done  (d2)
    );

    pattern_gen_ec #(.HOLD_CYCLES(1)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .letter_valid (v1),
        .letter_code  (c1),
        .letter_ready (r1),
        .OutputMSB    (m1),
        .OutputLSB    (l1),
        .tx_active    (a1),
        .letter_done  (d1)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the symbol stream one letter must produce.
    task automatic expect_letter(input int which, input logic code);
        int hold;
        logic [1:0] tail;
        hold = (which == 1) ? 1 : 2;
        tail = code ? 2'b00 : 2'b10;
        for (int h = 0; h < hold; h++) begin
            if (which == 1) q1.push_back(3'b110); else q2.push_back(3'b110);
        end
        for (int h = 0; h < hold; h++) begin
            if (which == 1) q1.push_back({tail, (h == hold - 1)});
            else            q2.push_back({tail, (h == hold - 1)});
        end
`ifdef PATTERN_GEN_EC_GAP_EN
        for (int h = 0; h < hold; h++) begin
            if (which == 1) q1.push_back(3'b000); else q2.push_back(3'b000);
        end
`endif
    endtask

    // Offer a letter and hold it until accepted (bounded).
    task automatic push_letter(input int which, input logic code);
        int n;
        n = 0;
        if (which == 1) begin
            v1 = 1'b1;
            c1 = code;
            while (!r1 && n < 100) begin tick(); n++; end
            check("push1_ready_timeout", {3'b0, r1}, 4'b0001);
        end else begin
            v2 = 1'b1;
            c2 = code;
            while (!r2 && n < 100) begin tick(); n++; end
            check("push2_ready_timeout", {3'b0, r2}, 4'b0001);
        end
        expect_letter(which, code);
        tick();
        v1 = 1'b0;
        v2 = 1'b0;
    endtask

    task automatic wait_idle(input int which, input string name);
        int n;
        n = 0;
        if (which == 1) begin
            while ((q1.size() != 0 || a1) && n < 200) begin tick(); n++; end
            check(name, {3'b0, (q1.size() == 0 && !a1)}, 4'b0001);
        end else begin
            while ((q2.size() != 0 || a2) && n < 200) begin tick(); n++; end
            check(name, {3'b0, (q2.size() == 0 && !a2)}, 4'b0001);
        end
    endtask

    // Monitor for the HOLD_CYCLES=2 instance.
    always @(negedge clk) begin
        logic [2:0] e;
        if (!rst) begin
            if (a2 && !a2_prev) bursts2++;
            a2_prev = a2;
            if (a2) begin
                if (q2.size() == 0) begin
                    check("dut2_unexpected_output", {1'b0, m2, l2, d2}, 4'b1111);
                end else begin
                    e = q2.pop_front();
                    check("dut2_symbol", {1'b0, m2, l2, d2}, {1'b0, e});
                end
            end else begin
                check("dut2_idle", {1'b0, m2, l2, d2}, 4'b0000);
            end
        end
    end

    // Monitor for the HOLD_CYCLES=1 instance.
    always @(negedge clk) begin
        logic [2:0] e;
        if (!rst) begin
            if (a1 && !a1_prev) bursts1++;
            a1_prev = a1;
            if (a1) begin
                if (q1.size() == 0) begin
                    check("dut1_unexpected_output", {1'b0, m1, l1, d1}, 4'b1111);
                end else begin
                    e = q1.pop_front();
                    check("dut1_symbol", {1'b0, m1, l1, d1}, {1'b0, e});
                end
            end else begin
                check("dut1_idle", {1'b0, m1, l1, d1}, 4'b0000);
            end
        end
    end

    initial begin
        int b0;

        // Reset state.
        repeat (3) tick();
        check("rst_dut2_outputs", {m2, l2, a2, d2}, 4'b0000);
        check("rst_dut2_ready",   {3'b0, r2}, 4'b0000);
        check("rst_dut1_outputs", {m1, l1, a1, d1}, 4'b0000);
        check("rst_dut1_ready",   {3'b0, r1}, 4'b0000);
        rst = 1'b0;
        tick();
        check("ready_after_rst2", {3'b0, r2}, 4'b0001);
        check("ready_after_rst1", {3'b0, r1}, 4'b0001);

        // Single E with first-symbol latency.
        b0 = bursts2;
        push_letter(2, 1'b0);
        check("lat_after_n",  {2'b0, m2, l2}, 4'b0000);
        tick();
        check("lat_after_n1", {2'b0, m2, l2}, 4'b0000);
        tick();
        check("lat_after_n2", {2'b0, m2, l2}, 4'b0011);
        wait_idle(2, "single_e_drain");
        check("single_e_bursts", 4'(bursts2 - b0), 4'd1);

        // E then C on consecutive cycles: one contiguous burst.
        b0 = bursts2;
        push_letter(2, 1'b0);
        push_letter(2, 1'b1);
        wait_idle(2, "ec_drain");
        check("ec_bursts", 4'(bursts2 - b0), 4'd1);

        // Three pushes behind a letter in flight; ready drops when full.
        b0 = bursts2;
        push_letter(2, 1'b0);
        push_letter(2, 1'b1);
        check("ready_one_queued", {3'b0, r2}, 4'b0001);
        push_letter(2, 1'b0);
        check("ready_full", {3'b0, r2}, 4'b0000);
        push_letter(2, 1'b1);
        wait_idle(2, "three_drain");
        check("three_bursts", 4'(bursts2 - b0), 4'd1);

        // Reset during HEAD of C with an E queued behind it.
        push_letter(2, 1'b1);
        push_letter(2, 1'b0);
        tick();
        check("rst_mid_head", {2'b0, m2, l2}, 4'b0011);
        rst = 1'b1;
        q2.delete();
        tick();
        check("rst_mid_outputs", {m2, l2, a2, d2}, 4'b0000);
        check("rst_mid_ready",   {3'b0, r2}, 4'b0000);
        rst = 1'b0;
        tick();
        check("rst_mid_ready_release", {3'b0, r2}, 4'b0001);
        repeat (6) tick();
        check("rst_mid_discard", {3'b0, a2}, 4'b0000);

        // HOLD_CYCLES=1: E, C, E contiguous, one cycle per symbol.
        b0 = bursts1;
        push_letter(1, 1'b0);
        push_letter(1, 1'b1);
        push_letter(1, 1'b0);
        wait_idle(1, "h1_drain");
        check("h1_bursts", 4'(bursts1 - b0), 4'd1);

        wait_idle(2, "final_drain2");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
